// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one result bit per clock.
// Optional signed-overflow flag output is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             br_nxt;
  logic             bit_res;
  logic             last_bit;
  logic             a_msb;
  logic             b_msb;
  logic [1:0]       hs0;
  logic [1:0]       hs1;

  // Half-subtractor cell: returns {borrow, difference}.
  function automatic logic [1:0] half_sub(input logic x, input logic y);
    return {~x & y, x ^ y};
  endfunction

  // Two chained half-subtractors form one full-subtractor bit step.
  always_comb begin
    hs0      = half_sub(a_sh[0], b_sh[0]);
    hs1      = half_sub(hs0[0], br);
    bit_res  = hs1[0];
    br_nxt   = hs0[1] | hs1[1];
    res_nxt  = {bit_res, res_sh[WIDTH-1:1]};
    last_bit = (cnt == LAST_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          br     <= br_nxt;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Visible results move only on the completion edge and are held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      borrow <= 1'b0;
    end else if (state == RUN && last_bit) begin
      diff   <= res_nxt;
      borrow <= br_nxt;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Overflow: operands of opposite sign and result sign differs from minuend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == RUN && last_bit) begin
      ovf <= (a_msb != b_msb) && (bit_res != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table vectors, hand sequences and random operations
// for serial_subtractor, checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  logic [W-1:0] last_d;
  logic         last_b;
  logic         last_o;
  int           done_cyc;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } vec_t;

  vec_t tab[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] d, output logic br, output logic ov);
    int ux, uy, sx, sy, sd;
    ux = int'(x);
    uy = int'(y);
    d  = W'(ux - uy);
    br = (ux < uy);
    sx = (ux >= 2 ** (W - 1)) ? ux - 2 ** W : ux;
    sy = (uy >= 2 ** (W - 1)) ? uy - 2 ** W : uy;
    sd = sx - sy;
    ov = (sd > 2 ** (W - 1) - 1) || (sd < -(2 ** (W - 1)));
  endfunction

  // Starts from the cycle before the IDLE cycle; ends sampling in the done cycle.
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input logic hold, input string nm);
    int nbad;
    @(negedge clk);
    chk({nm, " idle"}, 64'({busy, done}), 64'(2'b00));
    a = ai;
    b = bi;
    start = 1'b1;
    nbad = 0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if ({busy, done, diff, borrow} !== {1'b1, 1'b0, last_d, last_b}) nbad++;
`ifdef SERIAL_SUB_OVF_EN
      if (ovf !== last_o) nbad++;
`endif
      start = hold;
      a = W'($urandom);
      b = W'($urandom);
    end
    chk({nm, " run-phase bad cycles"}, 64'(nbad), 64'(0));
    @(negedge clk);
    chk({nm, " busy/done"}, 64'({busy, done}), 64'(2'b01));
    chk({nm, " diff"}, 64'(diff), 64'(ed));
    chk({nm, " borrow"}, 64'(borrow), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, " ovf"}, 64'(ovf), 64'(eo));
`endif
    last_d = ed;
    last_b = eb;
    last_o = eo;
    done_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, md;
    logic         mb, mo;
    int           c0, c1;
    int           ndone;

    tab[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tab[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tab[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tab[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tab[4] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    tab[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tab[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    tab[7] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tab[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};

    last_d = '0;
    last_b = 1'b0;
    last_o = 1'b0;
    done_cyc = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset state", 64'({busy, done, diff, borrow}), 64'(0));
`ifdef SERIAL_SUB_OVF_EN
    chk("reset ovf", 64'(ovf), 64'(0));
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Table vectors; the first is accepted on the first edge after reset release.
    for (int i = 0; i < 9; i++)
      do_op(tab[i].a, tab[i].b, tab[i].d, tab[i].br, tab[i].ov, 1'b0, $sformatf("vec%0d", i));

    // Start held high with operands churning during RUN.
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, "hold0");
    c0 = done_cyc;
    do_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "hold1");
    c1 = done_cyc;
    chk("hold accept spacing", 64'(c1 - c0), 64'(W + 2));
    do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, "hold2");
    chk("hold accept spacing 2", 64'(done_cyc - c1), 64'(W + 2));

    // Reset in RUN cycle 4 aborts and clears everything asynchronously.
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("run before reset", 64'({busy, done}), 64'(2'b10));
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", 64'({busy, done, diff, borrow}), 64'(0));
`ifdef SERIAL_SUB_OVF_EN
    chk("async reset ovf", 64'(ovf), 64'(0));
`endif
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) ndone++;
    end
    chk("no activity in reset", 64'(ndone), 64'(0));
    last_d = '0;
    last_b = 1'b0;
    last_o = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, "post-reset");

    // Random operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 6 == 0) rb = ra;
      model(ra, rb, md, mb, mo);
      do_op(ra, rb, md, mb, mo, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
    start = 1'b0;
    @(negedge clk);
    chk("final idle", 64'({busy, done, diff}), 64'({2'b00, last_d}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial unsigned subtractor: accepts two WIDTH-bit operands and computes `a - b` one bit per clock, LSB first.
- Each bit step is the two-stage half-subtractor chain `a^b` then `^borrow`, with the borrow carried in a flip-flop.
- Sits downstream of the half-subtractor cell as its sequential consumer, for area-constrained datapaths where one full-width subtractor is too costly.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when diff/borrow are updated.
- diff  output  WIDTH  result `a - b` modulo 2^WIDTH; registered, held between operations.
- borrow  output  1  final borrow out; 1 iff a < b unsigned; registered, held.
- ovf  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1: load shift registers with a and b, clear the internal borrow flop, clear the bit counter, go to RUN.
- IDLE with start=0: remain in IDLE.
- RUN, per edge, using d = a_sh[0], s = b_sh[0], br = borrow flop:
  - result bit = d ^ s ^ br.
  - br_next = (~d & s) | (~(d ^ s) & br).
  - Result bit shifts into the MSB of the internal result register; a_sh and b_sh shift right.
  - Counter increments.
- RUN exit: after exactly WIDTH RUN edges, go to DONE. On that same edge:
  - diff <= full result register.
  - borrow <= br_next.
  - ovf <= (a_msb != b_msb) && (result_msb != a_msb), using the latched operand MSBs.
- DONE: done=1 for one cycle, then unconditionally go to IDLE.
- start is ignored in RUN and DONE. There is no queueing and no abort.
- diff, borrow and ovf change only on the completion edge. They stay stable through the next operation's RUN phase.
- Counter width is clog2(WIDTH)+1. No wrap inside an operation.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, internal registers cleared.
- Reset release is synchronous to clk. The first start can be accepted on the first edge after rst_n rises.
- Reset mid-RUN aborts the operation. No done pulse is produced and prior diff/borrow are lost (cleared).
- Accept on the edge ending cycle t: busy=1 during cycles t+1 .. t+WIDTH.
- Completion: done=1 and busy=0 in cycle t+WIDTH+1; diff/borrow valid from that cycle.
- Latency from accepting edge to done: WIDTH+1 cycles.
- Earliest next accept: the edge ending cycle t+WIDTH+2 (back in IDLE). Throughput is one result per WIDTH+2 cycles.
- busy and done are never high in the same cycle.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - ovf port and its register exist.
  - ovf=1 when `a - b` overflows as WIDTH-bit two's complement.
  - ovf updates only on the completion edge.
- SERIAL_SUB_OVF_EN undefined:
  - ovf port and its register are absent.
  - All other behaviour and timing are identical.

## Test plan
All scenarios use WIDTH=8.
- Reset, then start with a=0x05, b=0x03 -> busy high 8 cycles; done pulse at cycle 9 after accept; diff=0x02, borrow=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1; with macro, ovf=0.
- a=0x80, b=0x01 (macro on) -> diff=0x7F, borrow=0, ovf=1. Back-to-back a=0x00, b=0x00 started in the first IDLE cycle -> diff=0x00, borrow=0, ovf=0.
- start held high continuously with a/b changed during RUN -> only the operands at each accepting edge are used; accepts occur every 10 cycles; diff stays at the previous result until each done.
- Assert rst_n=0 at RUN cycle 4 -> all outputs 0 immediately (asynchronously); no done; after release, a=0xFF, b=0x01 -> diff=0xFE, borrow=0.
